spi_reg_ctrl: RTL
=================

Name: spi_reg_ctrl

Overview:
- Command/register-access controller on the byte interface of the asynchronous SPI slave: decodes a command byte, then streams auto-incrementing register writes or reads against a simple register-bank port.
- Clocked by the slave's gated output clock (posedge) and reset by its slave-select-derived reset, so every SPI transaction starts from a clean state.
- Supplies the slave's next transmit byte (sdat) on every ready.

Parameters:
- NREG, 128, number of implemented registers (1..128); addresses >= NREG are out of range.
- STATUS, 8'hA5, constant byte returned during the byte after any command byte.

Ports:
- clk  input  1  controller clock; posedge only, runs only while the SPI clock toggles
- reset  input  1  asynchronous, active-high reset
- ready  input  1  high for one clk cycle at each byte boundary; mdat valid, sdat must be updated on this edge
- mdat  input  [0:7]  byte received from master, bit 0 = MSB
- sdat  output  [0:7]  byte to transmit next, registered
- reg_addr  output  [0:6]  register address, driven from the internal address counter
- reg_wdata  output  [0:7]  write data, registered
- reg_we  output  1  one-cycle write strobe
- reg_re  output  1  one-cycle read strobe; reg_rdata must be valid at the next posedge clk
- reg_rdata  input  [0:7]  register read data
- oor  output  1  sticky flag: an out-of-range access occurred in this transaction

Behaviour:
- Reset (async, any time, including mid-byte): state=CMD, addr=0, sdat=STATUS, reg_wdata=0, reg_we=0, reg_re=0, pbuf=0, oor=0, pend=0. A strobe scheduled but not yet issued is dropped.
- Command byte: mdat[0]=1 means read, 0 means write; mdat[1:7] is the start address.
- Strobe issue, common rule:
  - When pend=1 and ready=0, the next posedge asserts reg_we or reg_re for exactly one cycle and clears pend.
  - On the posedge that ends the strobe, addr increments modulo 128 (7-bit wrap: 127 -> 0).
  - If addr >= NREG when the strobe would issue: no strobe, oor <= 1, pbuf <= 8'h00 for reads, and addr still increments on that same edge.
- State CMD, on ready:
  - addr <= mdat[1:7]; sdat <= STATUS.
  - If read: state <= RD and pend <= 1 (prefetch of the start address).
  - If write: state <= WR.
- State WR, on ready:
  - reg_wdata <= mdat; sdat <= mdat (echo); pend <= 1.
  - Strobe is reg_we at reg_addr = addr, then post-increment.
- State RD:
  - Each reg_re cycle captures pbuf <= reg_rdata on the posedge ending the strobe.
  - On ready: sdat <= pbuf; pend <= 1 (fetch the next address).
  - mdat is ignored in RD.
- Resulting wire protocols:
  - Write: CMD, D0, D1, ... written to A, A+1, ...
  - Read: CMD, turnaround byte (master sends don't-care, receives STATUS), then D[A], D[A+1], ... on miso.
- Timing margin: ready recurs every 8 clk cycles; the strobe completes within 2 cycles of ready, so strobes and ready never coincide. A transaction ended after a partial byte has no effect beyond strobes already issued.
- State remains WR or RD until reset; there is no return to CMD within one transaction.
- reg_we and reg_re are never high in the same cycle. reg_addr is stable while either strobe is high.

Test Plan:
- Write burst: cmd 8'h05, data 8'h11, 8'h22 -> reg_we pulses at addr 5 with wdata 8'h11 and at addr 6 with 8'h22; sdat on successive ready edges = A5, 11, 22; oor=0.
- Read burst, bank holds [0x10]=8'h3C, [0x11]=8'h7E: cmd 8'h90, 3 dummy bytes -> miso bytes after cmd = A5, 3C, 7E; reg_re at 0x10, 0x11, 0x12.
- Wrap: write cmd 8'h7F, data 8'hAA, 8'hBB -> writes at 127 then 0.
- Out of range with NREG=16: write cmd 8'h0F, data 01, 02 -> one reg_we at 15, none at 16; oor=1. Read cmd 8'h90 -> data bytes 00 with no reg_re; oor=1.
- Reset mid-operation: deassert ss after 4 bits of the second data byte -> only the first write strobed; all outputs return to reset values. Next transaction with cmd 8'h02 and data 8'h55 behaves normally.
- Reset during pend: drop ss between ready and the strobe -> no reg_we issued.

Source files
------------

// File: rtl/spi_reg_ctrl.sv
// spi_reg_ctrl
//   Command/register-access controller behind the byte interface of an
//   asynchronous SPI slave. The first byte of a transaction is a command
//   (MSB = read flag, low 7 bits = start address). It is followed either by
//   auto-incrementing register writes or by auto-incrementing register reads
//   that are prefetched one byte ahead.
//
// Ports
//   clk        in   gated SPI-derived clock, posedge only
//   reset      in   async active-high reset (slave select inactive)
//   ready      in   one-cycle byte boundary pulse; mdat valid, sdat updated
//   mdat       in   [0:7] byte from master, bit 0 = MSB
//   sdat       out  [0:7] next byte to transmit (registered)
//   reg_addr   out  [0:6] register address (internal address counter)
//   reg_wdata  out  [0:7] register write data (registered)
//   reg_we     out  one-cycle write strobe
//   reg_re     out  one-cycle read strobe, data sampled on the next posedge
//   reg_rdata  in   [0:7] register read data
//   oor        out  sticky out-of-range flag for the current transaction
//
// State | meaning
//   CMD | waiting for the command byte
//   WR  | write burst: every data byte is written, address post-increments
//   RD  | read burst: every byte boundary sends the prefetched byte and
//       | fetches the next address
module spi_reg_ctrl #(
  parameter int          NREG   = 128,
  parameter logic [7:0]  STATUS = 8'hA5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ready,
  input  logic [0:7] mdat,
  output logic [0:7] sdat,
  output logic [0:6] reg_addr,
  output logic [0:7] reg_wdata,
  output logic       reg_we,
  output logic       reg_re,
  input  logic [0:7] reg_rdata,
  output logic       oor
);

  typedef enum logic [1:0] {
    CMD = 2'd0,
    WR  = 2'd1,
    RD  = 2'd2
  } state_t;

  localparam logic [7:0] NREG_W = 8'(NREG);

  state_t     state_q, state_d;
  logic [0:6] addr_q, addr_d;
  logic [0:7] sdat_q, sdat_d;
  logic [0:7] wdata_q, wdata_d;
  logic [0:7] pbuf_q, pbuf_d;
  logic       we_q, we_d;
  logic       re_q, re_d;
  logic       oor_q, oor_d;
  logic       pend_q, pend_d;
  logic       addr_oor;

  // Zero-extend so that NREG = 128 never flags an address as out of range.
  assign addr_oor = ({1'b0, addr_q} >= NREG_W);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= CMD;
      addr_q  <= '0;
      sdat_q  <= STATUS;
      wdata_q <= '0;
      pbuf_q  <= '0;
      we_q    <= 1'b0;
      re_q    <= 1'b0;
      oor_q   <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      sdat_q  <= sdat_d;
      wdata_q <= wdata_d;
      pbuf_q  <= pbuf_d;
      we_q    <= we_d;
      re_q    <= re_d;
      oor_q   <= oor_d;
      pend_q  <= pend_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    sdat_d  = sdat_q;
    wdata_d = wdata_q;
    pbuf_d  = pbuf_q;
    we_d    = 1'b0;
    re_d    = 1'b0;
    oor_d   = oor_q;
    pend_d  = pend_q;

    // Edge that ends a strobe: post-increment, and capture read data.
    if (we_q || re_q) begin
      addr_d = addr_q + 7'd1;
    end
    if (re_q) begin
      pbuf_d = reg_rdata;
    end

    // Pending access is issued in the first cycle after the byte boundary.
    // An out-of-range access is skipped but still advances the address so
    // the burst stays aligned with the master's byte count.
    if (pend_q && !ready) begin
      pend_d = 1'b0;
      if (addr_oor) begin
        oor_d  = 1'b1;
        addr_d = addr_q + 7'd1;
        if (state_q == RD) begin
          pbuf_d = '0;
        end
      end else if (state_q == RD) begin
        re_d = 1'b1;
      end else begin
        we_d = 1'b1;
      end
    end

    case (state_q)
      CMD: begin
        if (ready) begin
          addr_d = mdat[1:7];
          sdat_d = STATUS;
          if (mdat[0]) begin
            state_d = RD;
            pend_d  = 1'b1;
          end else begin
            state_d = WR;
          end
        end
      end
      WR: begin
        if (ready) begin
          wdata_d = mdat;
          sdat_d  = mdat;
          pend_d  = 1'b1;
        end
      end
      RD: begin
        if (ready) begin
          sdat_d = pbuf_q;
          pend_d = 1'b1;
        end
      end
      default: begin
        state_d = CMD;
      end
    endcase
  end

  assign sdat      = sdat_q;
  assign reg_addr  = addr_q;
  assign reg_wdata = wdata_q;
  assign reg_we    = we_q;
  assign reg_re    = re_q;
  assign oor       = oor_q;

endmodule
